// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Bundles the D-cache <-> data-memory bus. The cache side uses the
//   master modport and the memory responder uses the slave modport.
//   Signals:
//     proc2mem_addr     byte address (32 bits)
//     proc2mem_data     store data, lane-aligned as in memory
//     proc2mem_size     0 = BYTE, 1 = HALF, 2 = WORD
//     proc2mem_command  0 = BUS_NONE, 1 = BUS_LOAD, 2 = BUS_STORE
//     mem2proc_response accepted tag, 0 = rejected or idle
//     mem2proc_data     load data for the completing tag
//     mem2proc_tag      completing tag, 0 = no completion
interface dmem_responder_if;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic [1:0]  proc2mem_size;
  logic [1:0]  proc2mem_command;
  logic [3:0]  mem2proc_response;
  logic [31:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  modport master (
    output proc2mem_addr, proc2mem_data, proc2mem_size, proc2mem_command,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_addr, proc2mem_data, proc2mem_size, proc2mem_command,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the D-cache bus. Accepts loads and stores,
//   hands back the lowest free nonzero tag in the same cycle, and returns
//   each transaction with its tag LATENCY cycles after acceptance (stores
//   complete with data 0). Backed by a word-addressed array that is not
//   reset.
//   Ports:
//     clk   clock
//     rst   asynchronous, active-high reset
//     bus   dmem_responder_if.slave (request in, response/completion out)
//   Optional feature: define MEM_STALL_EN to reject every command once
//   every STALL_PERIOD cycles (exercises initiator retry).
module dmem_responder #(
  parameter int MEM_WORDS    = 1024,
  parameter int LATENCY      = 4,
  parameter int NUM_TAGS     = 15,
  parameter int STALL_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] MEM_BYTE  = 2'd0;
  localparam logic [1:0] MEM_HALF  = 2'd1;
  localparam int         IDXW      = $clog2(MEM_WORDS);

  logic [31:0]       mem_q [MEM_WORDS];
  logic [NUM_TAGS:1] busy_q, busy_d;
  logic [3:0]        pipe_tag_q  [LATENCY];
  logic [31:0]       pipe_data_q [LATENCY];

  logic [3:0]        free_tag;
  logic [3:0]        done_tag;
  logic              stall;
  logic              accept;
  logic              is_store;
  logic [IDXW-1:0]   idx;
  logic [3:0]        lane_we;
  logic [31:0]       rd_word;
  logic              unused_addr;

  // Upper address bits are ignored so the array aliases modulo its size.
  assign idx         = bus.proc2mem_addr[IDXW+1:2];
  assign unused_addr = ^bus.proc2mem_addr;
  assign is_store    = (bus.proc2mem_command == BUS_STORE);
  assign rd_word     = mem_q[idx];
  assign done_tag    = pipe_tag_q[LATENCY-1];

`ifdef MEM_STALL_EN
  localparam int SW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  assign stall       = (stall_cnt_q == SW'(STALL_PERIOD - 1));
  assign stall_cnt_d = stall ? '0 : stall_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end
`else
  assign stall = 1'b0;
`endif

  // Lowest-numbered free tag; scanning downward lets the lowest win.
  // Uses registered bitmap only, so a tag freed this cycle is not reissued.
  always_comb begin
    free_tag = 4'd0;
    for (int t = NUM_TAGS; t >= 1; t--) begin
      if (!busy_q[t]) free_tag = 4'(t);
    end
  end

  assign accept = !rst && (bus.proc2mem_command != BUS_NONE) &&
                  (free_tag != 4'd0) && !stall;

  assign bus.mem2proc_response = accept ? free_tag : 4'd0;
  assign bus.mem2proc_tag      = pipe_tag_q[LATENCY-1];
  assign bus.mem2proc_data     = pipe_data_q[LATENCY-1];

  always_comb begin
    case (bus.proc2mem_size)
      MEM_BYTE: lane_we = 4'b0001 << bus.proc2mem_addr[1:0];
      MEM_HALF: lane_we = bus.proc2mem_addr[1] ? 4'b1100 : 4'b0011;
      default:  lane_we = 4'b1111;
    endcase
  end

  // Accepted tag becomes busy; the completing tag is released. They can
  // never collide because only free tags are accepted.
  always_comb begin
    busy_d = busy_q;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (done_tag == 4'(t))           busy_d[t] = 1'b0;
      if (accept && free_tag == 4'(t)) busy_d[t] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Completion pipe; a zero tag marks an empty slot. The last stage is the
  // registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag_q[i]  <= 4'd0;
        pipe_data_q[i] <= 32'd0;
      end
    end else begin
      pipe_tag_q[0]  <= accept ? free_tag : 4'd0;
      pipe_data_q[0] <= (accept && !is_store) ? rd_word : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_tag_q[i]  <= pipe_tag_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && is_store) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_we[l]) mem_q[idx][8*l +: 8] <= bus.proc2mem_data[8*l +: 8];
      end
    end
  end

endmodule
